// File: rtl/prim_idx_seq_pkg.sv
// Types for the index sequencer.
package prim_idx_seq_pkg;

  typedef enum logic [1:0] {
    IdxSeqIdle,
    IdxSeqRun
  } idx_seq_state_e;

endpackage

// File: rtl/prim_util_pkg.sv
// Shared width helpers used to size index/count ports.
package prim_util_pkg;

  // Bits needed to represent values 0..value-1 (at least one bit).
  function automatic int vbits(int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/prim_idx_seq.sv
// Index sequencer: turns a captured item count N into indices 0, Step, 2*Step, ... < N
// on a valid/ready stream, with abort, clamping and a done/aborted completion pulse.
module prim_idx_seq
  import prim_util_pkg::*;
  import prim_idx_seq_pkg::*;
#(
  parameter int MaxItems = 16,
  parameter int Step     = 1,
  localparam int IdxW    = vbits(MaxItems),
  localparam int CntW    = vbits(MaxItems + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [CntW-1:0] cnt_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [IdxW-1:0] idx_o,
  output logic            last_o,
  output logic            done_o,
  output logic            aborted_o
);

  // Wide enough for idx + 2*Step so the look-ahead last compare never wraps.
  localparam int SumW = vbits(MaxItems + 2 * Step) + 1;

  idx_seq_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] ncap_q, ncap_d;
  logic            clamp_q, clamp_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [SumW-1:0] nxt;
  logic [SumW-1:0] nxt2;

  // Index of the following beat and the one after, used for the registered last flag.
  assign nxt  = SumW'(idx_q) + SumW'(Step);
  assign nxt2 = nxt + SumW'(Step);

  // Next-state and output decode; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ncap_d    = ncap_q;
    clamp_d   = clamp_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IdxSeqIdle: begin
        if (start_i) begin
          if (cnt_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = IdxSeqRun;
            idx_d   = '0;
            valid_d = 1'b1;
            if (cnt_i > CntW'(MaxItems)) begin
              ncap_d  = CntW'(MaxItems);
              clamp_d = 1'b1;
            end else begin
              ncap_d  = cnt_i;
              clamp_d = 1'b0;
            end
            last_d = SumW'(Step) >= SumW'(ncap_d);
          end
        end
      end
      IdxSeqRun: begin
        // Abort wins over a same-cycle handshake: the presented beat is dropped.
        if (abort_i) begin
          state_d   = IdxSeqIdle;
          valid_d   = 1'b0;
          last_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (ready_i) begin
          if (last_q) begin
            state_d   = IdxSeqIdle;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = clamp_q;
          end else begin
            idx_d  = nxt[IdxW-1:0];
            last_d = nxt2 >= SumW'(ncap_q);
          end
        end
      end
      default: begin
        state_d = IdxSeqIdle;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset suppresses any done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IdxSeqIdle;
      idx_q     <= '0;
      ncap_q    <= '0;
      clamp_q   <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ncap_q    <= ncap_d;
      clamp_q   <= clamp_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy_o    = (state_q == IdxSeqRun);
  assign valid_o   = valid_q;
  assign idx_o     = idx_q;
  assign last_o    = last_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;

  a_stable_under_stall: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o && !ready_i && !abort_i |=> valid_o && $stable(idx_o) && $stable(last_o));

  a_done_no_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |-> !valid_o);

  a_idx_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o |-> (SumW'(idx_o) < SumW'(ncap_q)));

endmodule

// File: tb/tb_prim_idx_seq.sv
// Directed bench for prim_idx_seq: Step=1 instance for most cases, Step=3 instance for stride.
module tb_prim_idx_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [4:0] cnt = '0;
  logic       busy, valid, last, done, aborted;
  logic [3:0] idx;

  logic       b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
  logic [4:0] b_cnt = '0;
  logic       b_busy, b_valid, b_last, b_done, b_aborted;
  logic [3:0] b_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prim_idx_seq #(.MaxItems(16), .Step(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cnt_i(cnt), .abort_i(abort),
    .busy_o(busy), .valid_o(valid), .ready_i(ready), .idx_o(idx), .last_o(last),
    .done_o(done), .aborted_o(aborted)
  );

  prim_idx_seq #(.MaxItems(16), .Step(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .cnt_i(b_cnt), .abort_i(b_abort),
    .busy_o(b_busy), .valid_o(b_valid), .ready_i(b_ready), .idx_o(b_idx), .last_o(b_last),
    .done_o(b_done), .aborted_o(b_aborted)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int t3_idx[6] = '{0, 1, 1, 1, 2, 3};
  bit t3_rdy[6] = '{1, 0, 0, 1, 1, 1};
  int b_exp[4]  = '{0, 3, 6, 9};
  int hs;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_idx", idx, 0);
    rst = 1'b0;
    step();

    // 1: N=5, ready held high -> 0..4 back-to-back, done after last
    start = 1'b1; cnt = 5'd5; ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t1_valid", valid, 1);
      chk("t1_busy", busy, 1);
      chk("t1_idx", idx, k);
      chk("t1_last", last, (k == 4) ? 1 : 0);
      chk("t1_done", done, 0);
      step();
    end
    chk("t1_done_pulse", done, 1);
    chk("t1_aborted", aborted, 0);
    chk("t1_valid_end", valid, 0);
    chk("t1_busy_end", busy, 0);
    step();
    chk("t1_done_clr", done, 0);

    // 2: N=0 -> no beats, done next cycle, not aborted
    start = 1'b1; cnt = 5'd0;
    step();
    start = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_valid", valid, 0);
    chk("t2_busy", busy, 0);
    chk("t2_aborted", aborted, 0);
    step();
    chk("t2_done_clr", done, 0);
    chk("t2_valid2", valid, 0);

    // 3: N=4 with ready pattern 1,0,0,1,1,1 -> held during stalls, 4 handshakes
    start = 1'b1; cnt = 5'd4;
    step();
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      ready = t3_rdy[c];
      chk("t3_valid", valid, 1);
      chk("t3_idx", idx, t3_idx[c]);
      chk("t3_last", last, (t3_idx[c] == 3) ? 1 : 0);
      if (valid && ready) hs++;
      step();
    end
    chk("t3_handshakes", hs, 4);
    chk("t3_done", done, 1);
    chk("t3_valid_end", valid, 0);
    ready = 1'b1;
    step();

    // 4: N=16, abort presented at idx=7 -> dropped, done+aborted; restart from 0
    start = 1'b1; cnt = 5'd16;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("t4_idx7", idx, 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_valid", valid, 0);
    chk("t4_done", done, 1);
    chk("t4_aborted", aborted, 1);
    chk("t4_busy", busy, 0);
    step();
    chk("t4_done_clr", done, 0);
    abort = 1'b1;              // ignored in IDLE
    step();
    abort = 1'b0;
    chk("t4_idle_abort", done, 0);
    start = 1'b1; cnt = 5'd3;
    step();
    start = 1'b0;
    chk("t4_restart_valid", valid, 1);
    chk("t4_restart_idx", idx, 0);
    repeat (3) step();
    chk("t4_restart_done", done, 1);
    chk("t4_restart_abrt", aborted, 0);
    step();

    // 5a: Step=3, N=10 -> 0,3,6,9 with last on 9
    b_start = 1'b1; b_cnt = 5'd10;
    step();
    b_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t5_s3_valid", b_valid, 1);
      chk("t5_s3_idx", b_idx, b_exp[k]);
      chk("t5_s3_last", b_last, (k == 3) ? 1 : 0);
      step();
    end
    chk("t5_s3_done", b_done, 1);
    chk("t5_s3_aborted", b_aborted, 0);
    chk("t5_s3_valid_end", b_valid, 0);

    // 5b: N=17 > MaxItems -> 0..15 then aborted with done
    start = 1'b1; cnt = 5'd17;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("t5_clamp_idx", idx, k);
      chk("t5_clamp_last", last, (k == 15) ? 1 : 0);
      chk("t5_clamp_done", done, 0);
      step();
    end
    chk("t5_clamp_end_done", done, 1);
    chk("t5_clamp_aborted", aborted, 1);
    chk("t5_clamp_valid", valid, 0);
    step();

    // 6: reset at idx=2 of N=8 -> reset values next cycle, no done; restart afterwards
    start = 1'b1; cnt = 5'd8;
    step();
    start = 1'b0;
    step(); step();
    chk("t6_idx2", idx, 2);
    rst = 1'b1;
    step();
    chk("t6_valid", valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_idx", idx, 0);
    chk("t6_last", last, 0);
    chk("t6_done", done, 0);
    chk("t6_aborted", aborted, 0);
    rst = 1'b0;
    step();
    chk("t6_no_done", done, 0);
    start = 1'b1; cnt = 5'd2;
    step();
    start = 1'b0;
    chk("t6_restart_valid", valid, 1);
    chk("t6_restart_idx", idx, 0);
    step();
    chk("t6_restart_last", last, 1);
    chk("t6_restart_idx1", idx, 1);
    step();
    chk("t6_restart_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
